// File: rtl/power_domain_sequencer.sv
// Power-gating sequencer for one switchable domain: orders clock gating, isolation,
// domain reset and the power switch, handshaking with the (active-low) switch ack.
module power_domain_sequencer #(
  parameter int ISO_CYCLES  = 4,
  parameter int RST_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwr_off_req_i,
  input  logic       pwr_on_req_i,
  input  logic       switch_ack_ni,
  output logic       switch_n_o,
  output logic       iso_en_o,
  output logic       domain_rst_o,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_OFF_CLK = 4'd1,
    ST_OFF_ISO = 4'd2,
    ST_OFF_RST = 4'd3,
    ST_OFF_SW  = 4'd4,
    ST_OFF     = 4'd5,
    ST_ON_SW   = 4'd6,
    ST_ON_RST  = 4'd7,
    ST_ON_ISO  = 4'd8,
    ST_ON_CLK  = 4'd9
  } state_t;

  localparam logic [7:0]  ISO_LOAD = 8'(ISO_CYCLES - 1);
  localparam logic [7:0]  RST_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [15:0]            timer_q, timer_d;
  logic                   sw_q, sw_d, iso_q, iso_d, rst_q, rst_d, clk_q, clk_d, to_q, to_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sync <= '0;
    end else begin
      ack_sync[0] <= switch_ack_ni;
      for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
    end
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
      timer_q <= '0;
      sw_q    <= 1'b0;
      iso_q   <= 1'b0;
      rst_q   <= 1'b0;
      clk_q   <= 1'b1;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sw_q    <= sw_d;
      iso_q   <= iso_d;
      rst_q   <= rst_d;
      clk_q   <= clk_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    sw_d    = sw_q;
    iso_d   = iso_q;
    rst_d   = rst_q;
    clk_d   = clk_q;
    to_d    = to_q;
    unique case (state_q)
      ST_ON: if (pwr_off_req_i) begin
        state_d = ST_OFF_CLK;
        clk_d   = 1'b0;
        to_d    = 1'b0;
      end
      ST_OFF_CLK: begin
        state_d = ST_OFF_ISO;
        iso_d   = 1'b1;
        cnt_d   = ISO_LOAD;
      end
      ST_OFF_ISO: if (cnt_q == '0) begin
        state_d = ST_OFF_RST;
        rst_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      ST_OFF_RST: begin
        state_d = ST_OFF_SW;
        sw_d    = 1'b1;
        timer_d = '0;
      end
      // Keep waiting past a timeout; only the flag records it
      ST_OFF_SW: if (ack_s) begin
        state_d = ST_OFF;
      end else begin
        if (timer_q == TMO_LAST) to_d = 1'b1;
        if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
      end
      ST_OFF: if (pwr_on_req_i) begin
        state_d = ST_ON_SW;
        sw_d    = 1'b0;
        timer_d = '0;
        to_d    = 1'b0;
      end
      ST_ON_SW: if (!ack_s) begin
        state_d = ST_ON_RST;
        cnt_d   = RST_LOAD;
      end else begin
        if (timer_q == TMO_LAST) to_d = 1'b1;
        if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
      end
      ST_ON_RST: if (cnt_q == '0) begin
        state_d = ST_ON_ISO;
        rst_d   = 1'b0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      ST_ON_ISO: begin
        state_d = ST_ON_CLK;
        iso_d   = 1'b0;
      end
      ST_ON_CLK: begin
        state_d = ST_ON;
        clk_d   = 1'b1;
      end
      default: state_d = ST_ON;
    endcase
  end

  assign switch_n_o   = sw_q;
  assign iso_en_o     = iso_q;
  assign domain_rst_o = rst_q;
  assign clk_en_o     = clk_q;
  assign timeout_o    = to_q;
  assign state_o      = state_q;
  assign busy_o       = (state_q != ST_ON) && (state_q != ST_OFF);

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Scoreboard bench: stimulus queues expected output-change events (edge, value);
// a negedge monitor pops one per observed output change and checks value and edge.
module tb_power_domain_sequencer;
  logic       clk = 1'b0;
  logic       rst_i, pwr_off_req_i, pwr_on_req_i, switch_ack_ni;
  logic       switch_n_o, iso_en_o, domain_rst_o, clk_en_o, busy_o, timeout_o;
  logic [3:0] state_o;

  power_domain_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .pwr_off_req_i(pwr_off_req_i), .pwr_on_req_i(pwr_on_req_i),
    .switch_ack_ni(switch_ack_ni), .switch_n_o(switch_n_o), .iso_en_o(iso_en_o),
    .domain_rst_o(domain_rst_o), .clk_en_o(clk_en_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // switch_n_o register plus 15 flops gives the 16-cycle switch ack latency
  logic [14:0] dly;
  logic        force_en, force_val;
  always @(posedge clk) begin
    if (rst_i) dly <= '0;
    else       dly <= {dly[13:0], switch_n_o};
  end
  assign switch_ack_ni = force_en ? force_val : dly[14];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [9:0] v; } ev_t;
  ev_t        q[$];
  int         total = 0, bad = 0;
  logic       mon_en = 1'b0;
  logic [9:0] prev, vec;
  assign vec = {state_o, switch_n_o, iso_en_o, domain_rst_o, clk_en_o, busy_o, timeout_o};

  always @(negedge clk) begin
    if (mon_en) begin
      if (vec !== prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, vec);
        end else begin
          ev_t e;
          e = q.pop_front();
          total++;
          if (vec !== e.v) begin
            bad++;
            $display("FAIL event_value cyc=%0d got=%b exp=%b", cyc, vec, e.v);
          end
          if (cyc != e.at) begin
            bad++;
            $display("FAIL event_edge got=%0d exp=%0d (value %b)", cyc, e.at, e.v);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        ev_t e;
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_event edge=%0d exp=%b got=%b", e.at, e.v, vec);
      end
      prev = vec;
    end
  end

  task automatic push(input int at, input logic [3:0] st, input logic sw, iso, rst,
                      input logic ck, busy, to);
    ev_t e;
    e.at = at;
    e.v  = {st, sw, iso, rst, ck, busy, to};
    q.push_back(e);
  endtask

  task automatic push_off(input int e0);
    push(e0,      4'd1, 0, 0, 0, 0, 1, 0);
    push(e0 + 1,  4'd2, 0, 1, 0, 0, 1, 0);
    push(e0 + 5,  4'd3, 0, 1, 1, 0, 1, 0);
    push(e0 + 6,  4'd4, 1, 1, 1, 0, 1, 0);
    push(e0 + 24, 4'd5, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic push_on(input int e0);
    push(e0,      4'd6, 0, 1, 1, 0, 1, 0);
    push(e0 + 18, 4'd7, 0, 1, 1, 0, 1, 0);
    push(e0 + 26, 4'd8, 0, 1, 0, 0, 1, 0);
    push(e0 + 27, 4'd9, 0, 0, 0, 0, 1, 0);
    push(e0 + 28, 4'd0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic issue(input logic on, input logic off, output int e0);
    @(negedge clk);
    pwr_on_req_i  = on;
    pwr_off_req_i = off;
    e0 = cyc + 1;
    @(negedge clk);
    pwr_on_req_i  = 1'b0;
    pwr_off_req_i = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain pending=%0d after %0d cycles", name, q.size(), budget);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    int e0;
    rst_i = 1'b1; pwr_on_req_i = 1'b0; pwr_off_req_i = 1'b0;
    force_en = 1'b0; force_val = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_i = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_idle", vec, {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    prev   = vec;
    mon_en = 1'b1;

    // Power off then on with the delayed ack model
    issue(1'b0, 1'b1, e0);
    push_off(e0);
    drain("off_seq", 200);
    issue(1'b1, 1'b0, e0);
    push_on(e0);
    drain("on_seq", 200);

    // Ack stuck low: sticky timeout, release, then on request clears it
    @(negedge clk);
    force_en = 1'b1; force_val = 1'b0;
    issue(1'b0, 1'b1, e0);
    push(e0,      4'd1, 0, 0, 0, 0, 1, 0);
    push(e0 + 1,  4'd2, 0, 1, 0, 0, 1, 0);
    push(e0 + 5,  4'd3, 0, 1, 1, 0, 1, 0);
    push(e0 + 6,  4'd4, 1, 1, 1, 0, 1, 0);
    push(e0 + 70, 4'd4, 1, 1, 1, 0, 1, 1);
    push(e0 + 83, 4'd5, 1, 1, 1, 0, 0, 1);
    while (cyc < e0 + 80) @(negedge clk);
    force_val = 1'b1;
    drain("timeout", 200);
    force_en = 1'b0;
    issue(1'b1, 1'b0, e0);
    push_on(e0);
    drain("on_clears_timeout", 200);

    // Illegal requests dropped; simultaneous on+off in ON acts only on off
    issue(1'b1, 1'b0, e0);
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b1, e0);
    push_off(e0);
    while (cyc < e0 + 1) @(negedge clk);
    begin
      int dummy;
      issue(1'b1, 1'b1, dummy);
    end
    drain("ignored_reqs", 200);
    issue(1'b1, 1'b0, e0);
    push_on(e0);
    drain("back_on", 200);

    // Reset while isolating returns straight to ON values
    issue(1'b0, 1'b1, e0);
    push(e0,     4'd1, 0, 0, 0, 0, 1, 0);
    push(e0 + 1, 4'd2, 0, 1, 0, 0, 1, 0);
    push(e0 + 2, 4'd0, 0, 0, 0, 1, 0, 0);
    while (cyc < e0 + 1) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk) rst_i = 1'b0;
    drain("mid_reset", 50);
    check("after_mid_reset", vec, {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end
endmodule
